exposure_readout_sequencer: RTL and testbench
=============================================

// Module: exposure_readout_sequencer
// PURPOSE
//  Sensor-side responder to the exposure trigger handshake. Accepts the active-low exp_trigger request,
//  times the exposure window, then drives row readout with re_busy asserted. De-assertion of re_busy
//  ends the frame and lets the trigger side re-arm for the next exposure.
//  Sits between the exposure trigger block and the row readout / DRAM writer path.
// PARAMETERS
//  EXP_W   24  width of exposure length in clk cycles
//  ROW_W   10  width of row count / row address
//  RCYC_W  16  width of per-row readout length in clk cycles
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous, active-high reset
//  exp_trigger  in   1       exposure request, active low; held low until re_busy is seen
//  exp_cycles   in   EXP_W   exposure length in cycles; 0 is treated as 1
//  n_rows       in   ROW_W   rows per frame; 0 means no readout rows
//  row_cycles   in   RCYC_W  cycles per row; 0 is treated as 1
//  fifo_full    in   1       downstream backpressure, checked at each row boundary
//  exposing     out  1       high during the exposure window
//  ext_trig_out out  1       1-cycle pulse on the first exposure cycle (drives slave cameras)
//  re_busy      out  1       readout busy; this is the handshake acknowledge
//  row_valid    out  1       1-cycle pulse on the first cycle of each row
//  row_addr     out  ROW_W   current row index, valid while re_busy
//  frame_done   out  1       1-cycle pulse after the last row
//  frame_cnt    out  16      frames completed (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, armed=0. Reset takes effect immediately, also mid-frame; any partial frame is dropped.
//  armed is set in IDLE whenever exp_trigger==1 is sampled. A request is accepted only when armed and exp_trigger==0.
//    A level held low across frames therefore never starts a second frame.
//  IDLE:   on accept at cycle T, latch exp_cycles, n_rows and row_cycles into shadow registers and clear armed.
//          Config inputs are ignored until the next accept.
//  EXPOSE: entered at T+1. exposing=1 for exactly max(exp_cycles,1) cycles. ext_trig_out pulses at T+1.
//  READ:   entered on the cycle after the last exposing cycle. re_busy=1 from the first READ cycle until the frame ends.
//          Row r occupies max(row_cycles,1) cycles. row_valid pulses with row_addr=r on the row's first cycle.
//          r runs 0..n_rows-1 with no wrap.
//  WAIT:   at a row end that is not the last row, if fifo_full=1, hold here. re_busy stays 1, row_valid=0.
//          The next row starts the cycle after fifo_full is sampled 0. fifo_full is not checked after the last row.
//  DONE:   one cycle with re_busy=1, frame_done=1. Then IDLE with re_busy=0.
//  n_rows=0: READ is skipped and DONE follows EXPOSE directly. re_busy is still high for exactly 1 cycle, so the requester releases.
//  Latency from accept to first row_valid: 1 + max(exp_cycles,1) cycles.
//  exp_trigger returning high mid-frame has no effect on the frame; it only sets armed once in IDLE.
//  All counters are down-counters loaded from the shadow registers; no arithmetic wider than the port widths.
// CONFIGURATION
//  FRAME_CNT_EN defined:  frame_cnt increments (mod 2^16, wraps 0xFFFF->0) on each frame_done; reset to 0.
//  FRAME_CNT_EN undefined: frame_cnt is tied to 16'd0 and no counter logic is generated.
// STRUCTURE
//  Shared header exp_seq_pkg.vh holds the state encodings (S_IDLE, S_EXPOSE, S_READ, S_WAIT, S_DONE)
//    and the default widths.
//  One sub-module, cycle_down_timer: load, count down, and a done flag. It is used for both the exposure
//    timer and the row timer. The top level keeps the FSM, armed flag, row counter and frame counter.
// TESTING
//  1 exp_cycles=5, n_rows=3, row_cycles=4, fifo_full=0 -> exposing 5 cycles; row_valid pulses at addr 0,1,2 spaced 4 cycles;
//    re_busy high 13 cycles; one frame_done.
//  2 exp_trigger held low after frame_done -> no new ext_trig_out until exp_trigger goes 1 then 0.
//  3 as test 1, fifo_full=1 for 10 cycles from the end of row 1 -> row 2 row_valid delayed by 10 cycles;
//    re_busy stays high throughout.
//  4 exp_cycles=0, n_rows=0 -> exposing 1 cycle, re_busy 1 cycle coincident with frame_done, back to IDLE.
//  5 rst pulsed during row 1 -> all outputs 0 without waiting for a clk edge; after release,
//    a fresh accept requires exp_trigger high then low.
//  6 closed loop with the exposure trigger block in master mode, config changed mid-frame -> frames use the latched
//    values; with FRAME_CNT_EN, frame_cnt=N after N frames.

Source files
------------

// File: rtl/exposure_readout_sequencer_pkg.sv
// exposure_readout_sequencer_pkg: shared state encoding and default widths
package exposure_readout_sequencer_pkg;
    localparam int EXP_W_DEF  = 24;
    localparam int ROW_W_DEF  = 10;
    localparam int RCYC_W_DEF = 16;
    typedef enum logic [2:0] {S_IDLE, S_EXPOSE, S_READ, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/exposure_readout_sequencer_if.sv
// exposure_readout_sequencer_if: trigger handshake, frame configuration and row readout signals
interface exposure_readout_sequencer_if
    import exposure_readout_sequencer_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int ROW_W  = ROW_W_DEF,
    parameter int RCYC_W = RCYC_W_DEF
);
    logic              exp_trigger;
    logic [EXP_W-1:0]  exp_cycles;
    logic [ROW_W-1:0]  n_rows;
    logic [RCYC_W-1:0] row_cycles;
    logic              fifo_full;
    logic              exposing;
    logic              ext_trig_out;
    logic              re_busy;
    logic              row_valid;
    logic [ROW_W-1:0]  row_addr;
    logic              frame_done;
    logic [15:0]       frame_cnt;
    modport master (
        output exp_trigger, exp_cycles, n_rows, row_cycles, fifo_full,
        input  exposing, ext_trig_out, re_busy, row_valid, row_addr, frame_done, frame_cnt
    );
    modport slave (
        input  exp_trigger, exp_cycles, n_rows, row_cycles, fifo_full,
        output exposing, ext_trig_out, re_busy, row_valid, row_addr, frame_done, frame_cnt
    );
endinterface

// File: rtl/exposure_readout_sequencer_cycle_down_timer.sv
// cycle_down_timer: loadable down-counter flagging the final cycle of a loaded interval
module cycle_down_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
    end
    assign done_o = cnt_q == W'(1);
endmodule

// File: rtl/exposure_readout_sequencer.sv
// exposure_readout_sequencer: exposure trigger responder that times exposure and sequences row readout
// Define FRAME_CNT_EN to build the frame counter; otherwise frame_cnt is tied to zero.
module exposure_readout_sequencer
    import exposure_readout_sequencer_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int ROW_W  = ROW_W_DEF,
    parameter int RCYC_W = RCYC_W_DEF
) (
    input logic clk,
    input logic rst,
    exposure_readout_sequencer_if.slave bus_if
);
    state_t            state_q;
    logic              armed_q, exposing_q, ext_trig_q, re_busy_q, row_valid_q, frame_done_q;
    logic [ROW_W-1:0]  rows_left_q, row_addr_q;
    logic [RCYC_W-1:0] row_cyc_q;
    logic              accept, exp_done, row_done, last_row, start_row;

    assign accept    = (state_q == S_IDLE) && armed_q && !bus_if.exp_trigger;
    // rows_left_q counts rows not yet started, so zero inside a row marks the last one
    assign last_row  = rows_left_q == '0;
    assign start_row = (state_q == S_EXPOSE && exp_done && !last_row) ||
                       (state_q == S_READ && row_done && !last_row && !bus_if.fifo_full) ||
                       (state_q == S_WAIT && !bus_if.fifo_full);

    cycle_down_timer #(.W(EXP_W)) u_exp_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .val_i  (bus_if.exp_cycles == '0 ? EXP_W'(1) : bus_if.exp_cycles),
        .done_o (exp_done)
    );

    cycle_down_timer #(.W(RCYC_W)) u_row_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (start_row),
        .val_i  (row_cyc_q == '0 ? RCYC_W'(1) : row_cyc_q),
        .done_o (row_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            armed_q      <= 1'b0;
            exposing_q   <= 1'b0;
            ext_trig_q   <= 1'b0;
            re_busy_q    <= 1'b0;
            row_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            rows_left_q  <= '0;
            row_addr_q   <= '0;
            row_cyc_q    <= '0;
        end else begin
            ext_trig_q   <= accept;
            row_valid_q  <= start_row;
            frame_done_q <= 1'b0;
            if (start_row) begin
                rows_left_q <= rows_left_q - ROW_W'(1);
                row_addr_q  <= (state_q == S_EXPOSE) ? '0 : row_addr_q + ROW_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    // A low trigger either consumes the arm (accept) or was never armed
                    armed_q <= bus_if.exp_trigger;
                    if (accept) begin
                        rows_left_q <= bus_if.n_rows;
                        row_cyc_q   <= bus_if.row_cycles;
                        exposing_q  <= 1'b1;
                        state_q     <= S_EXPOSE;
                    end
                end
                S_EXPOSE: if (exp_done) begin
                    exposing_q   <= 1'b0;
                    re_busy_q    <= 1'b1;
                    frame_done_q <= last_row;
                    state_q      <= last_row ? S_DONE : S_READ;
                end
                S_READ: if (row_done) begin
                    frame_done_q <= last_row;
                    state_q      <= last_row ? S_DONE : (bus_if.fifo_full ? S_WAIT : S_READ);
                end
                S_WAIT: if (!bus_if.fifo_full) state_q <= S_READ;
                S_DONE: begin
                    re_busy_q  <= 1'b0;
                    row_addr_q <= '0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_if.exposing     = exposing_q;
    assign bus_if.ext_trig_out = ext_trig_q;
    assign bus_if.re_busy      = re_busy_q;
    assign bus_if.row_valid    = row_valid_q;
    assign bus_if.row_addr     = row_addr_q;
    assign bus_if.frame_done   = frame_done_q;

`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_cnt_q <= '0;
        else if (frame_done_q) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
    assign bus_if.frame_cnt = frame_cnt_q;
`else
    assign bus_if.frame_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_exposure_readout_sequencer.sv
// tb_exposure_readout_sequencer: directed scoreboard bench for exposure_readout_sequencer
module tb_exposure_readout_sequencer;
    typedef struct { int addr; int cyc; } row_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   exp_n = 0, trig_n = 0, busy_n = 0, fd_seen = 0;
    row_t row_q[$];
    int   fd_q[$];
    int   trig_q[$];

`ifdef FRAME_CNT_EN
    localparam int FC_EN = 1;
`else
    localparam int FC_EN = 0;
`endif

    exposure_readout_sequencer_if bus ();
    exposure_readout_sequencer dut (.clk(clk), .rst(rst), .bus_if(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int mx1(input int v);
        return v == 0 ? 1 : v;
    endfunction

    function automatic logic [31:0] outs();
        return {1'b0, bus.exposing, bus.ext_trig_out, bus.re_busy, bus.row_valid,
                bus.frame_done, bus.row_addr, bus.frame_cnt};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Arms with a high trigger, then requests; expected event cycles go to the scoreboard
    task automatic start_frame(input int e, input int n, input int r,
                               input int stall_row, input int stall, output int d);
        bus.exp_trigger = 1'b1;
        bus.exp_cycles  = e[23:0];
        bus.n_rows      = n[9:0];
        bus.row_cycles  = r[15:0];
        exp_n = 0; trig_n = 0; busy_n = 0; fd_seen = 0;
        step(2);
        bus.exp_trigger = 1'b0;
        d = cyc;
        trig_q.push_back(d + 1);
        for (int i = 0; i < n; i++)
            row_q.push_back('{addr: i, cyc: d + 1 + mx1(e) + i * mx1(r) + (i >= stall_row ? stall : 0)});
        fd_q.push_back(d + 1 + mx1(e) + n * mx1(r) + stall);
    endtask

    task automatic end_frame(input int e, input int n, input int r, input int stall);
        for (int i = 0; i < 400 && fd_seen == 0; i++) step(1);
        step(2);
        chk("frame_done_seen", fd_seen, 1);
        chk("expose_cycles", exp_n, mx1(e));
        chk("trig_pulses", trig_n, 1);
        chk("busy_cycles", busy_n, n == 0 ? 1 : n * mx1(r) + stall + 1);
        chk("rows_pending", row_q.size(), 0);
        chk("done_pending", fd_q.size(), 0);
    endtask

    always @(negedge clk) begin : mon
        row_t e;
        if (bus.exposing) exp_n++;
        if (bus.re_busy) busy_n++;
        if (bus.ext_trig_out) begin
            trig_n++;
            chk("trig_expected", 32'(trig_q.size() != 0), 1);
            if (trig_q.size() != 0) chk("trig_cycle", cyc, trig_q.pop_front());
        end
        if (bus.row_valid) begin
            chk("row_busy", 32'(bus.re_busy), 1);
            chk("row_expected", 32'(row_q.size() != 0), 1);
            if (row_q.size() != 0) begin
                e = row_q.pop_front();
                chk("row_addr", 32'(bus.row_addr), e.addr);
                chk("row_cycle", cyc, e.cyc);
            end
        end
        if (bus.frame_done) begin
            fd_seen++;
            chk("done_busy", 32'(bus.re_busy), 1);
            chk("done_expected", 32'(fd_q.size() != 0), 1);
            if (fd_q.size() != 0) chk("done_cycle", cyc, fd_q.pop_front());
        end
    end

    initial begin
        int d;
        bus.exp_trigger = 1'b1;
        bus.exp_cycles  = '0;
        bus.n_rows      = '0;
        bus.row_cycles  = '0;
        bus.fifo_full   = 1'b0;
        #1 rst = 1'b1;
        #2 chk("reset_outputs", outs(), 0);
        step(2);
        rst = 1'b0;
        // Basic frame: 5 exposure cycles, 3 rows of 4 cycles
        start_frame(5, 3, 4, 0, 0, d);
        end_frame(5, 3, 4, 0);
        // Trigger still low: no second frame without a re-arm
        exp_n = 0; trig_n = 0;
        step(20);
        chk("no_retrigger", trig_n, 0);
        chk("no_reexpose", exp_n, 0);
        // Backpressure for 10 cycles at the end of row 1
        start_frame(5, 3, 4, 2, 10, d);
        step(13);
        bus.fifo_full = 1'b1;
        step(10);
        bus.fifo_full = 1'b0;
        end_frame(5, 3, 4, 10);
        // Zero exposure and zero rows
        start_frame(0, 0, 0, 0, 0, d);
        end_frame(0, 0, 0, 0);
        chk("frame_cnt_3", 32'(bus.frame_cnt), FC_EN != 0 ? 3 : 0);
        // Asynchronous reset in the middle of row 1
        start_frame(3, 4, 5, 0, 0, d);
        step(10);
        #2 chk("busy_before_rst", 32'(bus.re_busy), 1);
        rst = 1'b1;
        #1 chk("async_reset_outputs", outs(), 0);
        row_q.delete();
        fd_q.delete();
        trig_q.delete();
        step(2);
        rst = 1'b0;
        exp_n = 0; trig_n = 0;
        step(10);
        chk("no_accept_after_rst", trig_n, 0);
        chk("no_expose_after_rst", exp_n, 0);
        start_frame(1, 2, 2, 0, 0, d);
        end_frame(1, 2, 2, 0);
        // Config changes mid-frame must not affect the running frame
        start_frame(2, 2, 3, 0, 0, d);
        step(1);
        bus.exp_cycles = 24'd7;
        bus.n_rows     = 10'd5;
        bus.row_cycles = 16'd9;
        end_frame(2, 2, 3, 0);
        start_frame(4, 1, 0, 0, 0, d);
        step(3);
        bus.exp_cycles = 24'd0;
        bus.n_rows     = 10'd0;
        bus.row_cycles = 16'd2;
        end_frame(4, 1, 0, 0);
        chk("frame_cnt_after_rst", 32'(bus.frame_cnt), FC_EN != 0 ? 3 : 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
